pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 23 ++
 rtl/pipe_scoreboard.sv | 122 ++++++++++++
 rtl/pipeline_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared core definitions for the pipeline controller: FSM states,
// stage indices and the forward-select encoding.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } core_state_t;

    localparam int S_IF = 0;
    localparam int S_ID = 1;
    localparam int S_EX = 2;

    // Forward select: 0 reads the register file, any other value names the
    // pipeline stage whose result is bypassed to ID.
    localparam int FWD_RF = 0;

    function automatic logic [31:0] low_mask(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-stage instruction records plus the ID-source hazard and forwarding
// match logic used by pipeline_ctrl.
module pipe_scoreboard
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int FWD_EN     = 1,
    parameter int RA_W       = 5
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic [NUM_STAGES-1:0]         stage_en,
    input  logic [NUM_STAGES-1:0]         kill,
    input  logic [RA_W-1:0]               id_rs_num,
    input  logic [RA_W-1:0]               id_rt_num,
    input  logic                          id_uses_rs,
    input  logic                          id_uses_rt,
    input  logic                          id_wr_en,
    input  logic [RA_W-1:0]               id_wr_num,
    input  logic                          id_is_load,
    input  logic                          id_is_halt,
    output logic [NUM_STAGES-1:0]         stage_valid,
    output logic [NUM_STAGES-1:0]         halt_vec,
    output logic                          stall_req,
    output logic [$clog2(NUM_STAGES)-1:0] fwd_rs_sel,
    output logic [$clog2(NUM_STAGES)-1:0] fwd_rt_sel
);

    localparam int SEL_W = $clog2(NUM_STAGES);

    typedef struct packed {
        logic            wr_en;
        logic [RA_W-1:0] wr_num;
        logic            is_load;
        logic            is_halt;
    } rec_t;

    logic [NUM_STAGES-1:0] valid_reg;
    rec_t                  rec_reg [S_EX:NUM_STAGES-1];
    rec_t                  id_rec;
    logic                  id_valid;
    logic [NUM_STAGES-1:0] rs_hit;
    logic [NUM_STAGES-1:0] rt_hit;
    logic [SEL_W-1:0]      rs_idx;
    logic [SEL_W-1:0]      rt_idx;
    logic                  rs_stall;
    logic                  rt_stall;

    // IF and ID only need a valid bit; ID's fields arrive on the id_* inputs.
    assign id_rec = '{wr_en: id_wr_en, wr_num: id_wr_num,
                      is_load: id_is_load, is_halt: id_is_halt};
    assign id_valid    = valid_reg[S_ID];
    assign stage_valid = valid_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_reg <= '0;
            for (int s = S_EX; s < NUM_STAGES; s++) begin
                rec_reg[s] <= '0;
            end
        end else begin
            if (stage_en[S_IF]) begin
                valid_reg[S_IF] <= !kill[S_IF];
            end
            for (int s = S_ID; s < NUM_STAGES; s++) begin
                if (stage_en[s]) begin
                    valid_reg[s] <= valid_reg[s-1] && !kill[s];
                end
            end
            if (stage_en[S_EX]) begin
                rec_reg[S_EX] <= id_rec;
            end
            for (int s = S_EX + 1; s < NUM_STAGES; s++) begin
                if (stage_en[s]) begin
                    rec_reg[s] <= rec_reg[s-1];
                end
            end
        end
    end

    // WB is excluded from matching: the register file writes through.
    genvar gi;
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        if (gi >= S_EX && gi <= NUM_STAGES - 2) begin : g_live
            logic writer;
            assign writer     = valid_reg[gi] && rec_reg[gi].wr_en;
            assign rs_hit[gi] = id_valid && id_uses_rs && (id_rs_num != '0)
                                && writer && (rec_reg[gi].wr_num == id_rs_num);
            assign rt_hit[gi] = id_valid && id_uses_rt && (id_rt_num != '0)
                                && writer && (rec_reg[gi].wr_num == id_rt_num);
        end else begin : g_idle
            assign rs_hit[gi] = 1'b0;
            assign rt_hit[gi] = 1'b0;
        end

        if (gi == S_IF) begin : g_halt_if
            assign halt_vec[gi] = 1'b0;
        end else if (gi == S_ID) begin : g_halt_id
            assign halt_vec[gi] = valid_reg[gi] && id_is_halt;
        end else begin : g_halt_rec
            assign halt_vec[gi] = valid_reg[gi] && rec_reg[gi].is_halt;
        end
    end

    // Walk oldest to youngest so the nearest (lowest-index) producer wins.
    always_comb begin
        rs_idx = '0;
        rt_idx = '0;
        for (int s = NUM_STAGES - 2; s >= S_EX; s--) begin
            if (rs_hit[s]) rs_idx = SEL_W'(s);
            if (rt_hit[s]) rt_idx = SEL_W'(s);
        end
    end

    assign rs_stall  = (FWD_EN != 0) ? (rs_hit[S_EX] && rec_reg[S_EX].is_load) : (|rs_hit);
    assign rt_stall  = (FWD_EN != 0) ? (rt_hit[S_EX] && rec_reg[S_EX].is_load) : (|rt_hit);
    assign stall_req = rs_stall || rt_stall;

    assign fwd_rs_sel = ((FWD_EN != 0) && !rs_stall) ? rs_idx : SEL_W'(FWD_RF);
    assign fwd_rt_sel = ((FWD_EN != 0) && !rt_stall) ? rt_idx : SEL_W'(FWD_RF);

endmodule

// File: rtl/pipeline_ctrl.sv
// In-order pipeline controller: stage enables, flush/bubble insertion,
// load-use interlock, forward selects and the halt drain sequence.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int BR_STAGE   = 3,
    parameter int FWD_EN     = 1,
    parameter int RA_W       = 5
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic [RA_W-1:0]               id_rs_num,
    input  logic [RA_W-1:0]               id_rt_num,
    input  logic                          id_uses_rs,
    input  logic                          id_uses_rt,
    input  logic                          id_wr_en,
    input  logic [RA_W-1:0]               id_wr_num,
    input  logic                          id_is_load,
    input  logic                          id_is_halt,
    input  logic                          redirect,
    input  logic                          mem_busy,
    output logic [NUM_STAGES-1:0]         stage_en,
    output logic [NUM_STAGES-1:0]         stage_valid,
    output logic                          pc_enable,
    output logic [$clog2(NUM_STAGES)-1:0] fwd_rs_sel,
    output logic [$clog2(NUM_STAGES)-1:0] fwd_rt_sel,
    output logic                          halted
);

    // Stages younger than the branch stage are squashed on a redirect.
    localparam logic [NUM_STAGES-1:0] REDIR_KILL = NUM_STAGES'(low_mask(BR_STAGE));
    // A halt can only be flushed once it has left ID and is still below BR_STAGE.
    localparam logic [NUM_STAGES-1:0] HALT_FLUSH_MASK = REDIR_KILL & ~NUM_STAGES'(3);

    core_state_t           state_reg;
    core_state_t           state_next;
    logic [NUM_STAGES-1:0] kill;
    logic [NUM_STAGES-1:0] halt_vec;
    logic                  stall_req;
    logic                  flush_halt;

    pipe_scoreboard #(
        .NUM_STAGES (NUM_STAGES),
        .FWD_EN     (FWD_EN),
        .RA_W       (RA_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_b       (rst_b),
        .stage_en    (stage_en),
        .kill        (kill),
        .id_rs_num   (id_rs_num),
        .id_rt_num   (id_rt_num),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_wr_en    (id_wr_en),
        .id_wr_num   (id_wr_num),
        .id_is_load  (id_is_load),
        .id_is_halt  (id_is_halt),
        .stage_valid (stage_valid),
        .halt_vec    (halt_vec),
        .stall_req   (stall_req),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        stage_en   = '1;
        pc_enable  = 1'b1;
        kill       = '0;
        flush_halt = 1'b0;
        state_next = state_reg;

        if (state_reg == HALTED || mem_busy) begin
            stage_en  = '0;
            pc_enable = 1'b0;
        end else if (redirect) begin
            kill = REDIR_KILL;
        end else if (stall_req) begin
            stage_en[S_IF] = 1'b0;
            stage_en[S_ID] = 1'b0;
            pc_enable      = 1'b0;
            kill[S_EX]     = 1'b1;
        end

        // While draining, fetch stays frozen unless a redirect cancels the halt.
        if (state_reg == DRAIN) begin
            flush_halt = !mem_busy && redirect && (|(halt_vec & HALT_FLUSH_MASK));
            if (!flush_halt) begin
                pc_enable  = 1'b0;
                kill[S_IF] = 1'b1;
            end
        end

        case (state_reg)
            RUN: begin
                if (halt_vec[S_ID] && stage_en[S_ID] && !kill[S_EX]) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (flush_halt) begin
                    state_next = RUN;
                end else if (halt_vec[NUM_STAGES-2] && stage_en[NUM_STAGES-1]) begin
                    state_next = HALTED;
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    assign halted = (state_reg == HALTED);

endmodule
